// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b opcode/state types and pipeline constants
package lc3b_types;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    LU_STALL = 2'd2,
    FLUSH    = 2'd3
  } hazard_state_e;

  localparam logic [15:0] NOP_IR              = 16'h0000;
  localparam int          TIMEOUT_CYC_DEFAULT = 255;

  function automatic logic is_load(input opcode_e op);
    return op inside {OP_LDB, OP_LDI, OP_LDR};
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller pipeline/memory/perf signal bundle
interface pipeline_hazard_ctrl_if;

  logic [15:0] id_ex_ir;
  logic [15:0] ex_mem_ir;
  logic        br_taken;
  logic        imem_read;
  logic        imem_resp;
  logic        dmem_read;
  logic        dmem_write;
  logic        dmem_resp;
  logic        perf_clr;

  logic        load_pc;
  logic        load_if_id;
  logic        load_id_ex;
  logic        load_ex_mem;
  logic        load_mem_wb;
  logic        flush_front;
  logic        bubble_ex_mem;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [15:0] lu_events;
  logic [15:0] flush_events;
  logic        mem_timeout;

  modport master (
    output id_ex_ir, ex_mem_ir, br_taken, imem_read, imem_resp,
           dmem_read, dmem_write, dmem_resp, perf_clr,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_front, bubble_ex_mem, state, stall_cycles, lu_events,
           flush_events, mem_timeout
  );

  modport slave (
    input  id_ex_ir, ex_mem_ir, br_taken, imem_read, imem_resp,
           dmem_read, dmem_write, dmem_resp, perf_clr,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_front, bubble_ex_mem, state, stall_cycles, lu_events,
           flush_events, mem_timeout
  );

endinterface

// File: rtl/hazard_src_decode.sv
// rtl/hazard_src_decode.sv - source-register fields and use flags of one LC-3b instruction
module hazard_src_decode
  import lc3b_types::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  sr1,
  output logic        sr1_used,
  output logic [2:0]  sr2,
  output logic        sr2_used
);

  opcode_e op;
  logic    unused_imm_bits;

  assign op              = opcode_e'(ir[15:12]);
  assign sr1             = ir[8:6];
  assign unused_imm_bits = ^ir[4:3];

  always_comb begin
    sr1_used = 1'b0;
    sr2_used = 1'b0;
    sr2      = ir[2:0];
    case (op)
      OP_ADD, OP_AND: begin
        sr1_used = 1'b1;
        sr2_used = ~ir[5];
      end
      OP_NOT, OP_SHF, OP_LDB, OP_LDI, OP_LDR, OP_JMP: begin
        sr1_used = 1'b1;
      end
      // stores read their data register from the DR field
      OP_STB, OP_STI, OP_STR: begin
        sr1_used = 1'b1;
        sr2      = ir[11:9];
        sr2_used = 1'b1;
      end
      OP_JSR: begin
        sr1_used = ~ir[11];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/bubble control, perf counters and memory watchdog
module pipeline_hazard_ctrl
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  hazard_state_e state_q, next_state;
  logic          mem_stall, load_use;
  logic [2:0]    sr1, sr2, mem_dr;
  logic          sr1_used, sr2_used;
  logic          unused_mem_bits;
  logic          ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb;
  logic          flush_front, bubble_ex_mem;
  logic [15:0]   stall_cycles, lu_events, flush_events, consec;
  logic          mem_timeout;

  hazard_src_decode u_src_decode (
    .ir       (bus.id_ex_ir),
    .sr1      (sr1),
    .sr1_used (sr1_used),
    .sr2      (sr2),
    .sr2_used (sr2_used)
  );

  assign mem_stall = (bus.imem_read & ~bus.imem_resp)
                   | ((bus.dmem_read | bus.dmem_write) & ~bus.dmem_resp);

  assign mem_dr          = bus.ex_mem_ir[11:9];
  assign unused_mem_bits = ^bus.ex_mem_ir[8:0];
  assign load_use = is_load(opcode_e'(bus.ex_mem_ir[15:12]))
                  & ((sr1_used & (sr1 == mem_dr)) | (sr2_used & (sr2 == mem_dr)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= next_state;
  end

  always_comb begin
    next_state    = RUN;
    ld_pc         = 1'b1;
    ld_if_id      = 1'b1;
    ld_id_ex      = 1'b1;
    ld_ex_mem     = 1'b1;
    ld_mem_wb     = 1'b1;
    flush_front   = 1'b0;
    bubble_ex_mem = 1'b0;
    if (rst) begin
      {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb} = 5'b0;
      flush_front = 1'b1;
    end else if (mem_stall) begin
      next_state = MEM_WAIT;
      {ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb} = 5'b0;
    end else if (bus.br_taken) begin
      next_state    = FLUSH;
      flush_front   = 1'b1;
      bubble_ex_mem = 1'b1;
    end else if (load_use) begin
      // one bubble suffices: the load moves on to MEM/WB where forwarding reaches it
      next_state    = LU_STALL;
      ld_pc         = 1'b0;
      ld_if_id      = 1'b0;
      ld_id_ex      = 1'b0;
      bubble_ex_mem = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.perf_clr) begin
      stall_cycles <= 16'd0;
      lu_events    <= 16'd0;
      flush_events <= 16'd0;
      consec       <= 16'd0;
      mem_timeout  <= 1'b0;
    end else begin
      if ((mem_stall || load_use) && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (next_state == LU_STALL && state_q != LU_STALL && lu_events != 16'hFFFF)
        lu_events <= lu_events + 16'd1;
      if (next_state == FLUSH && state_q != FLUSH && flush_events != 16'hFFFF)
        flush_events <= flush_events + 16'd1;
      if (mem_stall) begin
        if (consec != TO_LIM) consec <= consec + 16'd1;
        if (consec == TO_LIM - 16'd1) mem_timeout <= 1'b1;
      end else begin
        consec <= 16'd0;
      end
    end
  end

  assign bus.load_pc       = ld_pc;
  assign bus.load_if_id    = ld_if_id;
  assign bus.load_id_ex    = ld_id_ex;
  assign bus.load_ex_mem   = ld_ex_mem;
  assign bus.load_mem_wb   = ld_mem_wb;
  assign bus.flush_front   = flush_front;
  assign bus.bubble_ex_mem = bubble_ex_mem;
  assign bus.state         = state_q;
  assign bus.stall_cycles  = stall_cycles;
  assign bus.lu_events     = lu_events;
  assign bus.flush_events  = flush_events;
  assign bus.mem_timeout   = mem_timeout;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001: Parameter TIMEOUT_CYC, default 255, is the number of consecutive memory-stall cycles after which mem_timeout is raised.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: id_ex_ir  input  16  instruction currently in EX stage.
REQ-005: ex_mem_ir  input  16  instruction currently in MEM stage.
REQ-006: br_taken  input  1  branch/jump in MEM stage resolved taken.
REQ-007: imem_read, imem_resp  input  1 each  instruction-memory request and completion.
REQ-008: dmem_read, dmem_write, dmem_resp  input  1 each  data-memory request and completion.
REQ-009: perf_clr  input  1  synchronous clear of all counters and mem_timeout.
REQ-010: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  pipeline-register load enables.
REQ-011: flush_front  output  1  when loading, IF/ID and ID/EX capture NOP (ir 0x0000, control zero).
REQ-012: bubble_ex_mem  output  1  when loading, EX/MEM captures NOP instead of the EX result.
REQ-013: state  output  2  current FSM state (RUN=0, MEM_WAIT=1, LU_STALL=2, FLUSH=3).
REQ-014: stall_cycles, lu_events, flush_events  output  16 each  saturating performance counters.
REQ-015: mem_timeout  output  1  sticky memory-stall watchdog flag.

Function
REQ-016: mem_stall = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp).
REQ-017: Sources of id_ex_ir: SR1 = [8:6] for add, and, not, shf, ldb, ldi, ldr, stb, sti, str, jmp, and jsr with [11]=0; SR2 = [2:0] for add/and with [5]=0; SR2 = [11:9] for stb, sti, str; other opcodes read no register.
REQ-018: load_use = ex_mem_ir opcode in {ldb, ldi, ldr} and ex_mem_ir[11:9] equals a used source of id_ex_ir.
REQ-019: Priority, combinational same cycle: rst > mem_stall > br_taken > load_use > normal.
REQ-020: mem_stall: all five load enables 0; flush_front 0; bubble_ex_mem 0.
REQ-021: br_taken without mem_stall: all load enables 1; flush_front 1; bubble_ex_mem 1.
REQ-022: load_use without mem_stall or br_taken: load_pc, load_if_id, load_id_ex 0; load_ex_mem, load_mem_wb 1; bubble_ex_mem 1.
REQ-023: Normal: all load enables 1; flush_front 0; bubble_ex_mem 0.
REQ-024: Next state = MEM_WAIT, FLUSH, LU_STALL, or RUN for the action selected under REQ-019; state reflects the previous cycle's action.
REQ-025: A load-use hazard yields exactly one bubble, because the bubble advances the load to MEM/WB, where the forwarding unit covers it.
REQ-026: stall_cycles increments every cycle with mem_stall or load_use asserted.
REQ-027: lu_events and flush_events increment once per LU_STALL and FLUSH entry, respectively.
REQ-028: All counters saturate at 0xFFFF.
REQ-029: A consecutive-stall counter counts mem_stall cycles and clears on any cycle without mem_stall.
REQ-030: mem_timeout sets when that count reaches TIMEOUT_CYC and stays set until rst or perf_clr.
REQ-031: perf_clr coincident with an increment clears; the clear wins.

Reset
REQ-032: While rst=1: all load enables 0; flush_front 1; bubble_ex_mem 0.
REQ-033: First edge with rst=1: state=RUN, all counters 0, mem_timeout 0.
REQ-034: rst asserted mid-stall or mid-flush abandons that operation; the first cycle after release evaluates REQ-019 afresh.

Structure
REQ-035: The opcode enum and the state enum live in the shared lc3b_types package.
REQ-036: NOP encoding (16'h0000) and TIMEOUT_CYC default live in the shared lc3b_types package.
REQ-037: Source-register decode (REQ-017) is one sub-module, hazard_src_decode, reusable by the forwarding unit.
REQ-038: The counters live inline.

Verification
REQ-039: ex_mem_ir=LDR R3 and id_ex_ir=ADD R1,R3,R2 -> one cycle with load_pc/if_id/id_ex=0, bubble_ex_mem=1, then RUN, lu_events=1.
REQ-040: ex_mem_ir=LDR R3 and id_ex_ir=ADD R1,R2,#3 (SR2 unused, [2:0]=3) -> no stall.
REQ-041: ex_mem_ir=LDR R3 and id_ex_ir=STR R3 (SR2=[11:9]) -> stall asserted.
REQ-042: br_taken=1 with load_use=1 -> flush_front=1, bubble_ex_mem=1, all loads 1, flush_events=1, lu_events=0.
REQ-043: dmem_read=1 held 300 cycles with dmem_resp=0 -> loads 0 throughout; mem_timeout sets at cycle 255; stall_cycles=300.
REQ-044: perf_clr pulse -> counters and mem_timeout 0 the next cycle.
